// File: rtl/key_breath_if.sv
// key_breath_if
//   Groups the push-key input and the outputs that go to the breathing stage
//   and other event consumers.
//   Signals:
//     key_n         raw push key, asynchronous, 0 = pressed
//     breath_valid  enable to the breath stage, 1 = breathing
//     key_short     one-cycle pulse, short press accepted
//     key_long      one-cycle pulse, long-press threshold reached
//   Modports:
//     master  drives key_n and observes the outputs (board / bench side)
//     slave   the controller itself
interface key_breath_if;
    logic key_n;
    logic breath_valid;
    logic key_short;
    logic key_long;

    modport master (
        output key_n,
        input  breath_valid,
        input  key_short,
        input  key_long
    );

    modport slave (
        input  key_n,
        output breath_valid,
        output key_short,
        output key_long
    );
endinterface

// File: rtl/key_breath_ctrl.sv
// key_breath_ctrl
//   Upstream controller for the 4-LED breathing stage. Synchronises and
//   debounces one active-low push key and classifies each press:
//     short press -> breath_valid toggles
//     long press  -> breath_valid forced to 0
//   It also emits one-cycle key_short / key_long pulses for other consumers.
//   Optional feature macro: KEY_AUTO_OFF_EN. When defined, breath_valid is
//   dropped after AUTO_OFF_MS of idling. When undefined, no idle counter is
//   built.
//   Ports:
//     sys_clk  system clock
//     rst      asynchronous reset, active high
//     bus      key_breath_if.slave (key_n in; breath_valid, key_short,
//              key_long out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | key released and stable
//   PRESS_DB | key seen low, waiting DEBOUNCE_MS of stable low
//   HELD     | press accepted, hold time counting toward LONG_MS
//   REL_DB   | key seen high after a press, waiting DEBOUNCE_MS stable
module key_breath_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int AUTO_OFF_MS = 60000
) (
    input  logic         sys_clk,
    input  logic         rst,
    key_breath_if.slave  bus
);

    localparam int DIV = CLK_FREQ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [15:0]   DB_LIM     = 16'(DEBOUNCE_MS);
    localparam logic [15:0]   LONG_LIM   = 16'(LONG_MS);
    localparam logic [15:0]   CNT_MAX    = 16'hFFFF;

    // Parameter sanity checks, resolved at elaboration.
    if (DIV < 1 || (CLK_FREQ % 1000) != 0) begin : g_bad_clk
        $error("key_breath_ctrl: CLK_FREQ must be a positive multiple of 1000");
    end
    if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 65535) begin : g_bad_db
        $error("key_breath_ctrl: DEBOUNCE_MS out of range");
    end
    if (LONG_MS <= DEBOUNCE_MS || LONG_MS > 65535) begin : g_bad_long
        $error("key_breath_ctrl: LONG_MS out of range");
    end
    if (AUTO_OFF_MS < 1 || AUTO_OFF_MS > 65535) begin : g_bad_auto
        $error("key_breath_ctrl: AUTO_OFF_MS out of range");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          key_s_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    logic [15:0]   db_cnt_q;
    logic [15:0]   db_cnt_d;
    logic [15:0]   hold_cnt_q;
    logic [15:0]   hold_cnt_d;
    logic          long_fired_q;
    logic          key_short_q;
    logic          key_long_q;
    logic          breath_q;
    logic          enter_held;

    // ms prescaler and saturating ms-counter increments
    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        db_cnt_d   = (tick && db_cnt_q != CNT_MAX) ? db_cnt_q + 16'd1 : db_cnt_q;
        hold_cnt_d = (tick && hold_cnt_q != CNT_MAX) ? hold_cnt_q + 16'd1 : hold_cnt_q;
        enter_held = (state_q == PRESS_DB && !key_s_q && db_cnt_q == DB_LIM) ||
                     (state_q == REL_DB && !key_s_q);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            key_s_q      <= 1'b1;
            presc_q      <= '0;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            key_short_q  <= 1'b0;
            key_long_q   <= 1'b0;
        end else begin
            sync1_q     <= bus.key_n;
            key_s_q     <= sync1_q;
            presc_q     <= presc_d;
            key_short_q <= 1'b0;
            key_long_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!key_s_q) begin
                        state_q  <= PRESS_DB;
                        db_cnt_q <= '0;
                    end
                end
                PRESS_DB: begin
                    if (key_s_q) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LIM) begin
                        state_q      <= HELD;
                        hold_cnt_q   <= '0;
                        long_fired_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_d;
                    end
                end
                HELD: begin
                    hold_cnt_q <= hold_cnt_d;
                    // long_fired keeps this to one pulse even if the
                    // counter stays at (or saturates past) the threshold
                    if (hold_cnt_q == LONG_LIM && !long_fired_q) begin
                        key_long_q   <= 1'b1;
                        long_fired_q <= 1'b1;
                    end
                    if (key_s_q) begin
                        state_q  <= REL_DB;
                        db_cnt_q <= '0;
                    end
                end
                REL_DB: begin
                    // a release glitch returns to HELD with hold state kept
                    if (!key_s_q) begin
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LIM) begin
                        state_q     <= IDLE;
                        key_short_q <= !long_fired_q;
                    end else begin
                        db_cnt_q <= db_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef KEY_AUTO_OFF_EN
    localparam logic [15:0] AUTO_LIM = 16'(AUTO_OFF_MS);

    logic [15:0] idle_cnt_q;
    logic [15:0] idle_cnt_d;

    always_comb begin
        idle_cnt_d = (tick && idle_cnt_q != CNT_MAX) ? idle_cnt_q + 16'd1 : idle_cnt_q;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
            breath_q   <= 1'b0;
        end else begin
            if (!breath_q || enter_held) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_d;
            end
            // key events take priority over the idle timeout
            if (key_long_q) begin
                breath_q <= 1'b0;
            end else if (key_short_q) begin
                breath_q <= !breath_q;
            end else if (breath_q && idle_cnt_q == AUTO_LIM) begin
                breath_q <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            breath_q <= 1'b0;
        end else if (key_long_q) begin
            breath_q <= 1'b0;
        end else if (key_short_q) begin
            breath_q <= !breath_q;
        end
    end

    // HELD entry only matters to the idle timer, which is not built here.
    logic unused_enter_held;
    assign unused_enter_held = enter_held;
`endif

    assign bus.breath_valid = breath_q;
    assign bus.key_short    = key_short_q;
    assign bus.key_long     = key_long_q;

endmodule

// File: tb/tb_key_breath_ctrl.sv
module tb_key_breath_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    int   short_cnt, long_cnt, short_wide, long_wide;
    int   short_cyc, long_cyc, rise_cyc, fall_cyc, fall_cnt;
    logic short_prev, long_prev, bv_prev;
    int   rel_cyc, press_cyc;
    int   s0, l0, f0;

    key_breath_if ifc ();

    key_breath_ctrl #(
        .CLK_FREQ   (10_000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20),
        .AUTO_OFF_MS(50)
    ) dut (
        .sys_clk(clk),
        .rst    (rst),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (ifc.key_short === 1'b1) begin
            short_cnt = short_cnt + 1;
            short_cyc = cyc;
            if (short_prev) short_wide = short_wide + 1;
        end
        if (ifc.key_long === 1'b1) begin
            long_cnt = long_cnt + 1;
            long_cyc = cyc;
            if (long_prev) long_wide = long_wide + 1;
        end
        if (ifc.breath_valid === 1'b1 && !bv_prev) rise_cyc = cyc;
        if (ifc.breath_valid === 1'b0 && bv_prev) begin
            fall_cyc = cyc;
            fall_cnt = fall_cnt + 1;
        end
        short_prev = (ifc.key_short === 1'b1);
        long_prev  = (ifc.key_long === 1'b1);
        bv_prev    = (ifc.breath_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int low_cycles, input int after_cycles);
        ifc.key_n = 1'b0;
        press_cyc = cyc;
        wait_cycles(low_cycles);
        ifc.key_n = 1'b1;
        rel_cyc = cyc;
        wait_cycles(after_cycles);
    endtask

    task automatic snap();
        s0 = short_cnt;
        l0 = long_cnt;
        f0 = fall_cnt;
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        short_cnt = 0; long_cnt = 0; short_wide = 0; long_wide = 0;
        short_cyc = 0; long_cyc = 0; rise_cyc = 0; fall_cyc = 0; fall_cnt = 0;
        short_prev = 1'b0; long_prev = 1'b0; bv_prev = 1'b0;
        rel_cyc = 0; press_cyc = 0;
        ifc.key_n = 1'b1;
        rst = 1'b1;
        wait_cycles(4);
        check("rst_bv", 32'(ifc.breath_valid), 0);
        check("rst_short", 32'(ifc.key_short), 0);
        check("rst_long", 32'(ifc.key_long), 0);
        rst = 1'b0;
        wait_cycles(20);

        // short press turns breathing on
        snap();
        press(100, 80);
        check("sp1_short_cnt", 32'(short_cnt - s0), 1);
        check("sp1_long_cnt", 32'(long_cnt - l0), 0);
        check("sp1_bv", 32'(ifc.breath_valid), 1);
        check("sp1_latency", 32'((short_cyc - rel_cyc) >= 30 && (short_cyc - rel_cyc) <= 50), 1);

        // reset mid-press clears everything at once
        ifc.key_n = 1'b0;
        wait_cycles(60);
        #2 rst = 1'b1;
        #1;
        check("midrst_bv", 32'(ifc.breath_valid), 0);
        check("midrst_short", 32'(ifc.key_short), 0);
        check("midrst_long", 32'(ifc.key_long), 0);
        ifc.key_n = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        snap();
        wait_cycles(100);
        check("postrst_short", 32'(short_cnt - s0), 0);
        check("postrst_long", 32'(long_cnt - l0), 0);
        check("postrst_bv", 32'(ifc.breath_valid), 0);

        // short press on, short press off
        snap();
        press(100, 80);
        check("sp2_short_cnt", 32'(short_cnt - s0), 1);
        check("sp2_bv", 32'(ifc.breath_valid), 1);
        snap();
        press(100, 80);
        check("sp3_short_cnt", 32'(short_cnt - s0), 1);
        check("sp3_long_cnt", 32'(long_cnt - l0), 0);
        check("sp3_bv", 32'(ifc.breath_valid), 0);
        check("short_width", 32'(short_wide), 0);

        // 2-cycle bounce for 10 cycles: rejected
        snap();
        for (int i = 0; i < 5; i++) begin
            ifc.key_n = i[0];
            wait_cycles(2);
        end
        ifc.key_n = 1'b1;
        wait_cycles(80);
        check("bounce_short", 32'(short_cnt - s0), 0);
        check("bounce_long", 32'(long_cnt - l0), 0);
        check("bounce_bv", 32'(ifc.breath_valid), 0);
        check("bounce_idle", 32'(dut.state_q), 0);

        // long press forces breathing off, no short on release
        press(100, 80);
        check("lp_pre_bv", 32'(ifc.breath_valid), 1);
        snap();
        press(400, 80);
        check("lp_long_cnt", 32'(long_cnt - l0), 1);
        check("lp_short_cnt", 32'(short_cnt - s0), 0);
        check("lp_bv", 32'(ifc.breath_valid), 0);
        check("lp_latency", 32'((long_cyc - press_cyc) >= 225 && (long_cyc - press_cyc) <= 260), 1);
        check("long_width", 32'(long_wide), 0);

        // release glitch mid-hold: one press, one short event
        snap();
        ifc.key_n = 1'b0;
        wait_cycles(80);
        ifc.key_n = 1'b1;
        wait_cycles(10);
        ifc.key_n = 1'b0;
        wait_cycles(60);
        ifc.key_n = 1'b1;
        wait_cycles(80);
        check("glitch_short", 32'(short_cnt - s0), 1);
        check("glitch_long", 32'(long_cnt - l0), 0);
        check("glitch_bv", 32'(ifc.breath_valid), 1);

`ifdef KEY_AUTO_OFF_EN
        press(100, 80);
        check("ao_pre_bv", 32'(ifc.breath_valid), 0);
        snap();
        press(100, 0);
        for (int i = 0; i < 800 && ifc.breath_valid !== 1'b0; i++) @(negedge clk);
        check("ao_fell", 32'(ifc.breath_valid), 0);
        check("ao_latency", 32'((fall_cyc - rise_cyc) >= 485 && (fall_cyc - rise_cyc) <= 510), 1);
        check("ao_no_pulse", 32'(short_cnt - s0), 1);

        // a press 300 cycles after turn-on restarts the timeout
        press(100, 0);
        for (int i = 0; i < 100 && ifc.breath_valid !== 1'b1; i++) @(negedge clk);
        check("ao2_on", 32'(ifc.breath_valid), 1);
        for (int i = 0; i < 400 && cyc < rise_cyc + 300; i++) @(negedge clk);
        snap();
        press(180, 80);
        check("ao2_short", 32'(short_cnt - s0), 1);
        check("ao2_bv", 32'(ifc.breath_valid), 0);
        check("ao2_falls", 32'(fall_cnt - f0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
